// File: rtl/ps2_kbd_tx_pkg.sv
// Shared definitions for the PS/2 keyboard-side transmitter: FSM encoding,
// frame length and default timing.
package ps2_kbd_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BIT_HI = 2'd1,
        BIT_LO = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam int unsigned FRAME_BITS   = 11;
    localparam int unsigned DEF_HALF_CYC = 4000;
    localparam int unsigned DEF_GAP_CYC  = 8000;

    // Frame as shifted out LSB first: start 0, data, odd parity, stop 1.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Byte FIFO for queued scan codes; power-of-two depth, registered status flags.
module ps2_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-to-host transmitter: queues scan-code bytes and clocks them out
// as 11-bit frames with a fixed idle gap between frames.
module ps2_kbd_tx
    import ps2_kbd_tx_pkg::*;
#(
    parameter int unsigned HALF_CYC   = DEF_HALF_CYC,
    parameter int unsigned GAP_CYC    = DEF_GAP_CYC,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned TMAX = (HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);
    localparam logic [3:0]    LAST_IDX  = 4'(FRAME_BITS - 1);

    state_t                  state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [3:0]              bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic                    ps2_clk_q, ps2_clk_d;
    logic                    ps2_data_q, ps2_data_d;
    logic                    frame_done_q, frame_done_d;
    logic                    busy_q, busy_d;

    logic                    fifo_pop;
    logic [7:0]              fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] unused_count;

    ps2_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_valid),
        .push_data(tx_data),
        .pop      (fifo_pop),
        .pop_data (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (unused_count)
    );

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        ps2_clk_d    = ps2_clk_q;
        ps2_data_d   = ps2_data_q;
        frame_done_d = 1'b0;
        fifo_pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = make_frame(fifo_dout);
                    bit_idx_d  = '0;
                    timer_d    = '0;
                    ps2_clk_d  = 1'b1;
                    ps2_data_d = shift_d[0];
                    state_d    = BIT_HI;
                end
            end
            BIT_HI: begin
                if (timer_q == HALF_LAST) begin
                    timer_d   = '0;
                    ps2_clk_d = 1'b0;
                    state_d   = BIT_LO;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            BIT_LO: begin
                if (timer_q == HALF_LAST) begin
                    timer_d   = '0;
                    ps2_clk_d = 1'b1;
                    // Data only moves on the rising edge, i.e. entry to BIT_HI.
                    if (bit_idx_q < LAST_IDX) begin
                        bit_idx_d  = bit_idx_q + 1'b1;
                        shift_d    = {1'b1, shift_q[FRAME_BITS-1:1]};
                        ps2_data_d = shift_d[0];
                        state_d    = BIT_HI;
                    end else begin
                        ps2_data_d   = 1'b1;
                        frame_done_d = 1'b1;
                        state_d      = GAP;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '1;
            ps2_clk_q    <= 1'b1;
            ps2_data_q   <= 1'b1;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            ps2_clk_q    <= ps2_clk_d;
            ps2_data_q   <= ps2_data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign tx_ready   = !fifo_full;
    assign ps2_clk    = ps2_clk_q;
    assign ps2_data   = ps2_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx with HALF_CYC=4, GAP_CYC=8, FIFO_DEPTH=4.
module tb_ps2_kbd_tx;

    localparam int unsigned HALF = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk, ps2_data, busy, frame_done;

    int unsigned tests = 0;
    int unsigned fails = 0;

    ps2_kbd_tx #(
        .HALF_CYC  (4),
        .GAP_CYC   (8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Line monitor sampled on the falling system-clock edge.
    int unsigned cyc = 0, run = 0, fd_cnt = 0, busy_cyc = 0;
    int unsigned phase_err = 0, data_err = 0, fd_cyc = 0, bf_cyc = 0;
    bit          bf_valid = 0;
    logic        prev_clk = 1'b1, prev_data = 1'b1, prev_busy = 1'b0, prev_rst = 1'b1;
    bit          bits_q[$];
    int unsigned gap_q[$];
    int unsigned idle_q[$];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            fd_cnt   = 0;
            busy_cyc = 0;
            bf_valid = 0;
            run      = 0;
        end else if (prev_rst) begin
            run = 1;
        end else begin
            if (ps2_clk !== prev_clk) begin
                if (run != HALF) phase_err++;
                if (!ps2_clk) bits_q.push_back(ps2_data);
                run = 1;
            end else if (busy && !prev_busy) begin
                run = 1;
            end else begin
                run++;
            end
            if (!ps2_clk && ps2_data !== prev_data) data_err++;
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            if (busy) busy_cyc++;
            if (!busy && prev_busy) begin
                gap_q.push_back(cyc - fd_cyc);
                bf_cyc   = cyc;
                bf_valid = 1;
            end
            if (busy && !prev_busy && bf_valid) idle_q.push_back(cyc - bf_cyc);
        end
        prev_clk  = ps2_clk;
        prev_data = ps2_data;
        prev_busy = busy;
        prev_rst  = rst;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bits_q.delete();
        gap_q.delete();
        idle_q.delete();
    endtask

    task automatic push(input logic [7:0] d, output bit rdy);
        rdy      = tx_ready;
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int unsigned n, input int unsigned budget, input string tag);
        int unsigned k = 0;
        while (!(fd_cnt >= n && !busy) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_timeout"}, 32'(k < budget), 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [10:0] exp);
        logic [15:0] got = 16'hFFFF;
        if (bits_q.size() >= 11) begin
            got = '0;
            for (int i = 0; i < 11; i++) got[i] = bits_q.pop_front();
        end
        check(tag, 32'(got), 32'(exp));
    endtask

    function automatic int unsigned q_head(input int unsigned q[$]);
        return (q.size() > 0) ? q[0] : 32'hDEAD;
    endfunction

    initial begin
        bit r0, r1, r2;
        bit rdy[6];

        // Reset state, with tx_valid held high throughout reset.
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ps2_clk", 32'(ps2_clk), 32'd1);
        check("rst_ps2_data", 32'(ps2_data), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        tx_valid = 1'b0;
        rst      = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("rst_valid_ignored_busy", 32'(busy), 32'd0);
        check("rst_valid_ignored_bits", 32'(bits_q.size()), 32'd0);

        // Single byte 0x1C: 0,0,0,1,1,1,0,0,0,0,1 and 96 busy cycles.
        do_reset();
        push(8'h1C, r0);
        wait_done(1, 400, "f1c");
        repeat (20) @(posedge clk);
        #1;
        check_frame("f1c_bits", 11'h438);
        check("f1c_frame_done", fd_cnt, 32'd1);
        check("f1c_busy_cycles", busy_cyc, 32'd96);
        check("f1c_gap", q_head(gap_q), 32'd8);

        // 0x00 then 0xFF: both parity bits 1, 8-cycle gap, one IDLE cycle between.
        do_reset();
        push(8'h00, r0);
        push(8'hFF, r1);
        wait_done(2, 800, "p2");
        repeat (20) @(posedge clk);
        #1;
        check_frame("p2_00_bits", 11'h600);
        check_frame("p2_ff_bits", 11'h7FE);
        check("p2_gap_first", q_head(gap_q), 32'd8);
        check("p2_idle_between", q_head(idle_q), 32'd1);
        check("p2_frame_done", fd_cnt, 32'd2);
        check("p2_busy_cycles", busy_cyc, 32'd192);

        // 0x11..0x16 on consecutive cycles: sixth refused on a full FIFO.
        do_reset();
        for (int i = 0; i < 6; i++) push(8'h11 + 8'(i), rdy[i]);
        check("full_ready_5th", 32'(rdy[4]), 32'd1);
        check("full_ready_6th", 32'(rdy[5]), 32'd0);
        wait_done(5, 2000, "full");
        repeat (300) @(posedge clk);
        #1;
        check("full_frame_done", fd_cnt, 32'd5);
        check_frame("full_11", 11'h622);
        check_frame("full_12", 11'h624);
        check_frame("full_13", 11'h426);
        check_frame("full_14", 11'h628);
        check_frame("full_15", 11'h42A);
        check("full_no_extra_bits", 32'(bits_q.size()), 32'd0);

        // 0xF0, 0x1C back-to-back: ready stays high, frames contiguous.
        do_reset();
        push(8'hF0, r0);
        push(8'h1C, r1);
        check("b2b_ready", 32'(r0 && r1), 32'd1);
        wait_done(2, 800, "b2b");
        #1;
        check_frame("b2b_f0", 11'h7E0);
        check_frame("b2b_1c", 11'h438);
        check("b2b_idle_between", q_head(idle_q), 32'd1);

        // Reset during bit 5 with two bytes queued.
        do_reset();
        push(8'hA1, r0);
        push(8'hB2, r1);
        push(8'hC3, r2);
        begin
            int unsigned k = 0;
            while (bits_q.size() < 6 && k < 200) begin
                @(posedge clk);
                #1;
                k++;
            end
            check("abort_reach_bit5", 32'(k < 200), 32'd1);
        end
        check("abort_clk_low_before", 32'(ps2_clk), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ps2_clk", 32'(ps2_clk), 32'd1);
        check("abort_ps2_data", 32'(ps2_data), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_frame_done", 32'(frame_done), 32'd0);
        check("abort_tx_ready", 32'(tx_ready), 32'd1);
        rst = 1'b0;
        bits_q.delete();
        repeat (400) @(posedge clk);
        #1;
        check("abort_no_frame_done", fd_cnt, 32'd0);
        check("abort_no_busy", busy_cyc, 32'd0);
        check("abort_no_bits", 32'(bits_q.size()), 32'd0);

        check("line_phase_length", phase_err, 32'd0);
        check("line_data_stable_clk_low", data_err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
